// File: rtl/bus_pkg.sv
// s_port_gen2 shared types: rx FSM states and the request record.
// Default frame widths live here; S_PORT_PARITY_EN is handled in the top.
package bus_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 8;
  localparam int WR_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ADDR     = 2'd0,
    WAIT_DEC = 2'd1,
    DATA     = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic                  rw;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } req_t;

endpackage

// File: rtl/s_port_gen2_if.sv
// Slave-side bundle of s_port_gen2: request FIFO head and read-data offer.
// master = the target port, slave = the attached slave device.
interface s_port_gen2_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              s_req_valid;
  logic              s_req_ready;
  logic              s_req_rw;
  logic [ADDR_W-1:0] s_address_in;
  logic [DATA_W-1:0] s_data_in;
  logic [DATA_W-1:0] s_data_out;
  logic              s_data_out_valid;
  logic              s_data_out_ready;

  modport master (
    output s_req_valid,
    output s_req_rw,
    output s_address_in,
    output s_data_in,
    output s_data_out_ready,
    input  s_req_ready,
    input  s_data_out,
    input  s_data_out_valid
  );

  modport slave (
    input  s_req_valid,
    input  s_req_rw,
    input  s_address_in,
    input  s_data_in,
    input  s_data_out_ready,
    output s_req_ready,
    output s_data_out,
    output s_data_out_valid
  );

endinterface

// File: rtl/tgt_req_fifo.sv
// Request FIFO for s_port_gen2: DEPTH entries (power of 2), explicit count.
// Push while full is accepted only when a pop frees the head that cycle.
module tgt_req_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_q];

  // next pointers and occupancy; pointers wrap naturally
  always_comb begin
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // pointer and count state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage; read side is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= wdata;
    end
  end

endmodule

// File: rtl/s_port_gen2.sv
// Serial-bus target port: LSB-first frame rx, request FIFO, read-data tx.
// Optional S_PORT_PARITY_EN adds even parity to rx fields and tx data.
module s_port_gen2
  import bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WR_DEPTH = WR_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bus_data_in,
  input  logic          bus_data_in_valid,
  input  logic          bus_mode,
  input  logic          decoder_valid,
  input  logic          bus_rw,
  s_port_gen2_if.master sif,
  output logic          bus_data_out,
  output logic          bus_data_out_valid,
  output logic          bus_s_ready,
  output logic          req_drop
);

`ifdef S_PORT_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int TX_W   = DATA_W + 1;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int TX_W   = DATA_W;
`endif

  localparam int REQ_W = 1 + ADDR_W + DATA_W;
  localparam int FMAX  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(FMAX + 2);
  localparam int FC_W  = $clog2(WR_DEPTH) + 1;
  localparam int TC_W  = $clog2(TX_W);

  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] A_PAR  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] D_PAR  = CNT_W'(DATA_W);
  localparam logic [TC_W-1:0]  T_LAST = TC_W'(TX_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rw_q, rw_d;
  logic              drop_q, drop_d;

  logic              rx_bit;
  logic              push_en;
  logic              fr_drop;
  logic [REQ_W-1:0]  push_req;

  logic [REQ_W-1:0]  head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FC_W-1:0]   fifo_cnt;
  logic              pop;
  logic              ovf;
  logic              push_ok;

  logic [TX_W-1:0]   tx_word;
  logic [TX_W-1:0]   tx_sh_q, tx_sh_d;
  logic [TC_W-1:0]   tx_left_q, tx_left_d;
  logic              tx_ready_q, tx_ready_d;
  logic              tx_bit_q, tx_bit_d;
  logic              tx_vld_q, tx_vld_d;

  // half-duplex: the bus is ours to listen to only while tx is idle
  assign rx_bit  = bus_data_in_valid & tx_ready_q;

  assign pop     = ~fifo_empty & sif.s_req_ready;
  assign ovf     = push_en & fifo_full & ~pop;
  assign push_ok = push_en & ~ovf;
  assign drop_d  = fr_drop | ovf;

  assign sif.s_req_valid = ~fifo_empty;
  assign {sif.s_req_rw, sif.s_address_in, sif.s_data_in} = head;
  assign bus_s_ready     = rst_n & (fifo_cnt != FC_W'(WR_DEPTH));
  assign req_drop        = drop_q;

  tgt_req_fifo #(
    .WIDTH(REQ_W),
    .DEPTH(WR_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_ok),
    .pop  (pop),
    .wdata(push_req),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );

  // rx frame FSM: shift in fields, decide push / abort / parity drop
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rw_d     = rw_q;
    push_en  = 1'b0;
    fr_drop  = 1'b0;
    push_req = '0;
    unique case (state_q)
      ADDR: begin
        if (rx_bit && !bus_mode) begin
          if (PAR_EN && cnt_q == A_PAR) begin
            cnt_d = '0;
            if (^addr_q ^ bus_data_in) begin
              fr_drop = 1'b1;
              addr_d  = '0;
              rw_d    = 1'b0;
            end else begin
              state_d = WAIT_DEC;
            end
          end else begin
            addr_d = {bus_data_in, addr_q[ADDR_W-1:1]};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == A_LAST) begin
              rw_d = bus_rw;
              if (!PAR_EN) begin
                cnt_d   = '0;
                state_d = WAIT_DEC;
              end
            end
          end
        end
      end
      WAIT_DEC: begin
        if (decoder_valid) begin
          cnt_d = '0;
          if (rw_q) begin
            state_d = DATA;
          end else begin
            push_en  = 1'b1;
            push_req = {1'b0, addr_q, {DATA_W{1'b0}}};
            state_d  = ADDR;
            addr_d   = '0;
          end
        end else if (!bus_data_in_valid && !bus_mode) begin
          fr_drop = 1'b1;
          state_d = ADDR;
          cnt_d   = '0;
          addr_d  = '0;
          rw_d    = 1'b0;
        end
      end
      DATA: begin
        if (rx_bit && bus_mode) begin
          if (PAR_EN && cnt_q == D_PAR) begin
            state_d = ADDR;
            cnt_d   = '0;
            addr_d  = '0;
            data_d  = '0;
            rw_d    = 1'b0;
            if (^data_q ^ bus_data_in) begin
              fr_drop = 1'b1;
            end else begin
              push_en  = 1'b1;
              push_req = {1'b1, addr_q, data_q};
            end
          end else begin
            data_d = {bus_data_in, data_q[DATA_W-1:1]};
            cnt_d  = cnt_q + 1'b1;
            if (!PAR_EN && cnt_q == D_LAST) begin
              push_en  = 1'b1;
              push_req = {1'b1, addr_q, data_d};
              state_d  = ADDR;
              cnt_d    = '0;
              addr_d   = '0;
              data_d   = '0;
              rw_d     = 1'b0;
            end
          end
        end
      end
      default: state_d = ADDR;
    endcase
  end

  // rx state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ADDR;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      drop_q  <= drop_d;
    end
  end

  // parity bit sits above the data; cast drops it when parity is off
  assign tx_word = TX_W'({^sif.s_data_out, sif.s_data_out});

  assign sif.s_data_out_ready = tx_ready_q;
  assign bus_data_out         = tx_bit_q;
  assign bus_data_out_valid   = tx_vld_q;

  // tx shifter: bit 0 goes out right after load, then one bit per cycle
  always_comb begin
    tx_ready_d = tx_ready_q;
    tx_sh_d    = tx_sh_q;
    tx_left_d  = tx_left_q;
    tx_bit_d   = tx_bit_q;
    tx_vld_d   = tx_vld_q;
    if (tx_ready_q) begin
      if (sif.s_data_out_valid) begin
        tx_ready_d = 1'b0;
        tx_bit_d   = tx_word[0];
        tx_vld_d   = 1'b1;
        tx_sh_d    = tx_word >> 1;
        tx_left_d  = T_LAST;
      end
    end else if (tx_left_q == '0) begin
      tx_ready_d = 1'b1;
      tx_vld_d   = 1'b0;
      tx_bit_d   = 1'b0;
    end else begin
      tx_bit_d  = tx_sh_q[0];
      tx_sh_d   = tx_sh_q >> 1;
      tx_left_d = tx_left_q - 1'b1;
    end
  end

  // tx state registers; ready idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready_q <= 1'b1;
      tx_sh_q    <= '0;
      tx_left_q  <= '0;
      tx_bit_q   <= 1'b0;
      tx_vld_q   <= 1'b0;
    end else begin
      tx_ready_q <= tx_ready_d;
      tx_sh_q    <= tx_sh_d;
      tx_left_q  <= tx_left_d;
      tx_bit_q   <= tx_bit_d;
      tx_vld_q   <= tx_vld_d;
    end
  end

endmodule
